// File: rtl/cosine_pkg.sv
// Shared definitions for the cosine sequencer and its datapath: state codes,
// distance width and the Q5.11 unit constant.
package cosine_pkg;

  localparam int DW = 16;
  localparam logic [DW-1:0] ONE = 16'h0800;

  typedef enum logic [2:0] {
    StandBy           = 3'd0,
    Alert             = 3'd1,
    StartCalculation  = 3'd2,
    AccumulateTerms   = 3'd3,
    CalculateDistance = 3'd4,
    Evaluate          = 3'd5
  } cosState_t;

  // Bits needed to count 0..maxVal-1.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal);
  endfunction

endpackage

// File: rtl/cosine_controller_if.sv
// Request/result handshake and datapath link between the sequencer (slave)
// and its requester plus datapath (master).
interface cosine_controller_if;
  import cosine_pkg::*;

  logic          start_req;
  logic          start_ack;
  logic          abort;
  logic [DW-1:0] threshold;
  logic          done;
  logic [DW-1:0] distance;
  logic [2:0]    state;
  logic          busy;
  logic          result_valid;
  logic [DW-1:0] result;
  logic          alert;
  logic          timeout_err;

  modport slave (
    input  start_req, abort, threshold, done, distance,
    output start_ack, state, busy, result_valid, result, alert, timeout_err
  );

  modport master (
    output start_req, abort, threshold, done, distance,
    input  start_ack, state, busy, result_valid, result, alert, timeout_err
  );
endinterface

// File: rtl/cosine_controller_term_counter.sv
// Loadable up-counter whose terminal-count flag compares against a runtime
// limit, so one instance can serve several phases with different lengths.
module term_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] last,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     count <= '0;
    else if (load)  count <= '0;
    else if (inc)   count <= count + W'(1);
  end

  assign tc = (count == last);

endmodule

// File: rtl/cosine_controller.sv
// Sequencer in front of the cosine/distance datapath: one Taylor evaluation per
// accepted request, distance-vs-threshold check and a timed alert.
//
// state             | meaning
// StandBy           | idle, accepts start_req
// StartCalculation  | one-cycle kick of the datapath
// AccumulateTerms   | N_TERMS series-term cycles
// CalculateDistance | one-cycle distance computation
// Evaluate          | wait for done, bounded by DONE_TIMEOUT
// Alert             | distance below threshold, held ALERT_CYCLES cycles
module cosine_controller
  import cosine_pkg::*;
#(
  parameter int N_TERMS      = 6,
  parameter int ALERT_CYCLES = 1000,
  parameter int DONE_TIMEOUT = 15
) (
  input logic                clk,
  input logic                rst_n,
  cosine_controller_if.slave bus
);

  localparam int TW = cntWidth((N_TERMS > DONE_TIMEOUT) ? N_TERMS : DONE_TIMEOUT);
  localparam int AW = cntWidth(ALERT_CYCLES);
  localparam logic [TW-1:0] TermLast  = TW'(N_TERMS - 1);
  localparam logic [TW-1:0] EvalLast  = TW'(DONE_TIMEOUT - 1);
  localparam logic [AW-1:0] AlertLast = AW'(ALERT_CYCLES - 1);

  cosState_t     stateQ, stateD;
  logic          accept, capture, timeoutHit;
  logic          termTc, alertTc, termLoad;
  logic [TW-1:0] termLast;
  logic [DW-1:0] thrQ, resultQ;
  logic          ackQ, busyQ, alertQ, captureQ, validQ, errQ;

  // Terms and done-timeout share one counter; they never overlap in time.
  assign termLoad = !(stateQ inside {AccumulateTerms, Evaluate});
  assign termLast = (stateQ == Evaluate) ? EvalLast : TermLast;

  term_counter #(.W(TW)) uTermCnt (
    .clk(clk), .rst_n(rst_n), .load(termLoad), .inc(!termLoad),
    .last(termLast), .tc(termTc)
  );

  term_counter #(.W(AW)) uAlertCnt (
    .clk(clk), .rst_n(rst_n), .load(stateQ != Alert), .inc(stateQ == Alert),
    .last(AlertLast), .tc(alertTc)
  );

  always_comb begin
    stateD     = StandBy;
    accept     = 1'b0;
    capture    = 1'b0;
    timeoutHit = 1'b0;
    case (stateQ)
      StandBy: begin
        if (bus.start_req && !bus.abort) begin
          stateD = StartCalculation;
          accept = 1'b1;
        end
      end
      StartCalculation:  stateD = AccumulateTerms;
      AccumulateTerms:   stateD = termTc ? CalculateDistance : AccumulateTerms;
      CalculateDistance: stateD = Evaluate;
      Evaluate: begin
        if (bus.done) begin
          capture = 1'b1;
          stateD  = (bus.distance < thrQ) ? Alert : StandBy;
        end else if (termTc) begin
          timeoutHit = 1'b1;
        end else begin
          stateD = Evaluate;
        end
      end
      Alert:   stateD = alertTc ? StandBy : Alert;
      default: stateD = StandBy;
    endcase
    if (bus.abort && stateQ != StandBy) begin
      stateD     = StandBy;
      capture    = 1'b0;
      timeoutHit = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= StandBy;
      thrQ     <= '0;
      resultQ  <= '0;
      ackQ     <= 1'b0;
      busyQ    <= 1'b0;
      alertQ   <= 1'b0;
      captureQ <= 1'b0;
      validQ   <= 1'b0;
      errQ     <= 1'b0;
    end else begin
      stateQ   <= stateD;
      ackQ     <= accept;
      busyQ    <= (stateD != StandBy);
      alertQ   <= (stateD == Alert);
      captureQ <= capture;
      validQ   <= captureQ;
      if (accept)  thrQ    <= bus.threshold;
      if (capture) resultQ <= bus.distance;
      if (accept)          errQ <= 1'b0;
      else if (timeoutHit) errQ <= 1'b1;
    end
  end

  assign bus.state        = stateQ;
  assign bus.start_ack    = ackQ;
  assign bus.busy         = busyQ;
  assign bus.alert        = alertQ;
  assign bus.result_valid = validQ;
  assign bus.result       = resultQ;
  assign bus.timeout_err  = errQ;

endmodule

// File: tb/tb_cosine_controller.sv
// Directed bench for cosine_controller with a tiny datapath model that raises
// done in the first Evaluate cycle when enabled.
module tb_cosine_controller;

  logic        clk;
  logic        rst_n;
  logic        doneEn;
  logic [15:0] distVal;
  int          total = 0;
  int          bad   = 0;

  cosine_controller_if dp();

  cosine_controller #(.N_TERMS(6), .ALERT_CYCLES(5), .DONE_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(dp)
  );

  assign dp.done     = doneEn && (dp.state == 3'd5);
  assign dp.distance = distVal;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  // Accept a request and follow it to the first Evaluate cycle (cycle 8).
  task automatic runToEval(input logic [15:0] thr, input logic [15:0] dv, input logic de);
    dp.threshold = thr;
    distVal      = dv;
    doneEn       = de;
    dp.start_req = 1'b1;
    waitCycle();
    chk("ack", {31'd0, dp.start_ack}, 1);
    chk("st_start", {29'd0, dp.state}, 2);
    chk("err_clr", {31'd0, dp.timeout_err}, 0);
    dp.start_req = 1'b0;
    dp.threshold = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      waitCycle();
      chk("st_acc", {29'd0, dp.state}, 3);
      if (i == 0) chk("ack_pulse", {31'd0, dp.start_ack}, 0);
    end
    waitCycle();
    chk("st_cd", {29'd0, dp.state}, 4);
    waitCycle();
    chk("st_eval", {29'd0, dp.state}, 5);
    chk("rv_early", {31'd0, dp.result_valid}, 0);
  endtask

  initial begin
    int   alertCnt;
    int   evalCnt;
    logic rvSeen;

    rst_n = 1'b0; dp.start_req = 1'b0; dp.abort = 1'b0; dp.threshold = '0;
    doneEn = 1'b0; distVal = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {29'd0, dp.state}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      waitCycle();
      chk("idle", {8'd0, dp.start_ack, dp.busy, dp.result_valid, dp.alert,
                   dp.timeout_err, dp.state, dp.result}, 0);
    end

    // Nominal, no alert
    runToEval(16'h0400, 16'h0C00, 1'b1);
    waitCycle();
    chk("nom_st9", {29'd0, dp.state}, 0);
    chk("nom_res9", {16'd0, dp.result}, 32'h0C00);
    chk("nom_rv9", {31'd0, dp.result_valid}, 0);
    waitCycle();
    chk("nom_rv10", {31'd0, dp.result_valid}, 1);
    chk("nom_alert", {31'd0, dp.alert}, 0);
    chk("nom_busy", {31'd0, dp.busy}, 0);
    waitCycle();
    chk("nom_rv11", {31'd0, dp.result_valid}, 0);

    // Alert path, request held during Alert
    runToEval(16'h0400, 16'h0200, 1'b1);
    waitCycle();
    chk("alt_st", {29'd0, dp.state}, 1);
    chk("alt_on", {31'd0, dp.alert}, 1);
    dp.start_req = 1'b1;
    alertCnt = 1;
    rvSeen   = 1'b0;
    for (int i = 0; i < 20 && dp.alert; i++) begin
      waitCycle();
      rvSeen |= dp.result_valid;
      if (dp.alert) begin
        alertCnt++;
        chk("alt_noack", {31'd0, dp.start_ack}, 0);
      end
    end
    chk("alt_len", alertCnt, 5);
    chk("alt_rv", {31'd0, rvSeen}, 1);
    chk("alt_res", {16'd0, dp.result}, 32'h0200);
    chk("alt_back", {29'd0, dp.state}, 0);
    chk("alt_ack_late", {31'd0, dp.start_ack}, 0);
    waitCycle();
    chk("alt_ack", {31'd0, dp.start_ack}, 1);
    chk("alt_restart", {29'd0, dp.state}, 2);
    dp.start_req = 1'b0;
    dp.abort     = 1'b1;
    waitCycle();
    dp.abort = 1'b0;
    chk("abort_sc", {29'd0, dp.state}, 0);
    waitCycle();
    chk("abort_sc_rv", {31'd0, dp.result_valid}, 0);

    // Equal threshold: strict less-than, so no alert
    runToEval(16'h0800, 16'h0800, 1'b1);
    waitCycle();
    chk("eq_st", {29'd0, dp.state}, 0);
    chk("eq_alert", {31'd0, dp.alert}, 0);
    waitCycle();
    chk("eq_rv", {31'd0, dp.result_valid}, 1);
    chk("eq_res", {16'd0, dp.result}, 32'h0800);

    // Done timeout
    runToEval(16'h0400, 16'h0100, 1'b0);
    evalCnt = 1;
    rvSeen  = 1'b0;
    for (int i = 0; i < 20 && dp.state == 3'd5; i++) begin
      waitCycle();
      rvSeen |= dp.result_valid;
      if (dp.state == 3'd5) evalCnt++;
    end
    chk("to_len", evalCnt, 4);
    chk("to_st", {29'd0, dp.state}, 0);
    chk("to_err", {31'd0, dp.timeout_err}, 1);
    waitCycle();
    rvSeen |= dp.result_valid;
    chk("to_norv", {31'd0, rvSeen}, 0);
    chk("to_sticky", {31'd0, dp.timeout_err}, 1);
    chk("to_hold", {16'd0, dp.result}, 32'h0800);
    runToEval(16'h0400, 16'h0C00, 1'b1);
    waitCycle();
    waitCycle();
    chk("to_next_rv", {31'd0, dp.result_valid}, 1);

    // Abort in third AccumulateTerms cycle
    dp.threshold = 16'h0400; distVal = 16'h0200; doneEn = 1'b1;
    dp.start_req = 1'b1;
    waitCycle();
    chk("ab_ack", {31'd0, dp.start_ack}, 1);
    dp.start_req = 1'b0;
    repeat (3) waitCycle();
    chk("ab_acc3", {29'd0, dp.state}, 3);
    dp.abort = 1'b1;
    waitCycle();
    dp.abort = 1'b0;
    chk("ab_st", {29'd0, dp.state}, 0);
    rvSeen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      waitCycle();
      rvSeen |= dp.result_valid | dp.alert;
    end
    chk("ab_norv", {31'd0, rvSeen}, 0);
    chk("ab_noerr", {31'd0, dp.timeout_err}, 0);

    // Asynchronous reset mid-Evaluate
    runToEval(16'h0400, 16'h0C00, 1'b0);
    waitCycle();
    chk("ar_eval", {29'd0, dp.state}, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_st", {29'd0, dp.state}, 0);
    chk("ar_busy", {31'd0, dp.busy}, 0);
    chk("ar_res", {16'd0, dp.result}, 0);
    #1 rst_n = 1'b1;
    waitCycle();
    chk("ar_idle", {29'd0, dp.state}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cosine_controller.md
Name: cosine_controller

Overview:
- Sequencing FSM directly upstream of the cosine/distance datapath.
- Drives the datapath's 3-bit state bus through one Taylor-series evaluation per accepted request.
- Waits for the datapath done flag, then compares the returned distance against a threshold.
- Raises a timed alert when the distance is below the threshold; otherwise returns to StandBy.

Parameters:
- N_TERMS, 6, number of AccumulateTerms cycles per evaluation; legal 1..8 (coefficient ROM index is 3 bits).
- ALERT_CYCLES, 1000, maximum cycles spent in Alert before auto-return to StandBy; legal >= 1.
- DONE_TIMEOUT, 15, maximum cycles spent waiting in Evaluate for done; legal >= 2.
- DW, 16, distance width (Q5.11 fixed point).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_req  in  1  request a new evaluation; level, held until start_ack.
- start_ack  out  1  one-cycle pulse when a request is accepted.
- abort  in  1  synchronous abort, returns the FSM to StandBy.
- threshold  in  DW  alert threshold, unsigned Q5.11; sampled at acceptance.
- done  in  1  datapath done flag.
- distance  in  DW  datapath distance result.
- state  out  3  datapath state code.
- busy  out  1  high whenever state != StandBy.
- result_valid  out  1  one-cycle pulse when a result is captured.
- result  out  DW  last captured distance; holds until the next capture.
- alert  out  1  high exactly while state == Alert.
- timeout_err  out  1  sticky; set on done timeout; cleared only by the next acceptance.

Behaviour:
State encoding is shared with the datapath:
- StandBy=0, Alert=1, StartCalculation=2, AccumulateTerms=3, CalculateDistance=4, Evaluate=5.
- Codes 6 and 7 are illegal; they decode to StandBy on the next edge.

Reset (rst_n low, asynchronous):
- state=StandBy; all outputs 0; result=0; term counter=0; threshold register=0.

Transitions, one per rising edge:
- StandBy: if start_req=1 and abort=0 -> StartCalculation.
  - Same cycle: start_ack=1, threshold latched, timeout_err cleared.
- StartCalculation: lasts exactly 1 cycle -> AccumulateTerms; term counter loads 0.
- AccumulateTerms: counter increments every cycle.
  - When counter == N_TERMS-1 -> CalculateDistance.
  - The state therefore holds for exactly N_TERMS cycles.
- CalculateDistance: 1 cycle -> Evaluate; wait counter loads 0.
- Evaluate: waits for done=1.
  - On done=1: result <= distance and result_valid pulses on the following cycle.
  - If distance < threshold (unsigned) -> Alert with alert counter loaded 0; else -> StandBy.
  - If done is still 0 after DONE_TIMEOUT cycles in Evaluate -> StandBy, timeout_err=1, no result_valid.
- Alert: counter increments; when counter == ALERT_CYCLES-1 -> StandBy.
  - start_req is not acknowledged in Alert.

Rules across all states:
- abort=1 in any non-StandBy state -> StandBy on the next edge.
  - No result_valid, no error; abort has priority over every other transition.
- Done in Evaluate and timeout expiring in the same cycle: done wins.
- distance == threshold: no alert (strict less-than).

Latency, request accept to result_valid:
- 1 + N_TERMS + 1 + k + 1 cycles, where k is the number of cycles spent in Evaluate (k >= 1).
- With the current datapath, done is high in the first Evaluate cycle, so k=1 and the default total is 10 cycles.

Additional constraints:
- All outputs are registered.
- state changes only on clock edges; no combinational path from inputs to state.

Decomposition:
- Shared package cosine_pkg holds the state codes, the Q5.11 ONE constant (16'h0800) and DW.
- The datapath is converted to import the same codes.
- One sub-module, term_counter: a loadable up-counter with terminal-count compare.
  - Instantiated twice: once for terms/timeout, once for alert duration.

Test Plan:
- Reset then idle: rst_n low 3 cycles then high, no start_req -> state=0, busy=0, all outputs 0 for 20 cycles.
- Nominal no-alert evaluation:
  - threshold=16'h0400, start_req=1, datapath model returns distance=16'h0C00 with done in the first Evaluate cycle.
  - Required: start_ack at cycle 0, state sequence 2,3x6,4,5,0.
  - Required: result_valid at cycle 10 with result=16'h0C00; alert=0.
- Alert path: distance=16'h0200, threshold=16'h0400, ALERT_CYCLES=5 -> alert high exactly 5 cycles, then StandBy.
  - A start_req held during Alert is acked only in the cycle after the return to StandBy.
- Equal-threshold boundary: distance=threshold=16'h0800 -> no alert, result_valid=1.
- Timeout: done held 0, DONE_TIMEOUT=4 -> Evaluate lasts 4 cycles, then StandBy with timeout_err=1 and no result_valid.
  - The next accepted start_req clears timeout_err.
- Abort and async reset:
  - abort pulse in the 3rd AccumulateTerms cycle -> StandBy next edge, no result_valid.
  - rst_n low mid-Evaluate -> state=0 immediately, without waiting for a clock edge.
